// File: rtl/axi4_wr_mix_interconnect_m2s.sv
// Write-path interconnect: NUM upstream AXI4 write ports merged onto one downstream port.
// Optional debug tracking registers: define AXI4_WR_MIX_INTERCONNECT_TRACK_EN.
module axi4_wr_mix_interconnect_m2s #(
   parameter int NUM    = 8,
   parameter int WDEPTH = 4,
   parameter int ID_W   = 2,
   parameter int MID_W  = ID_W + $clog2(NUM),
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                          axi_aclk,
   input  logic                          axi_aresetn,
   // upstream write ports
   input  logic [NUM-1:0]                slv_awvalid,
   output logic [NUM-1:0]                slv_awready,
   input  logic [NUM-1:0][ID_W-1:0]      slv_awid,
   input  logic [NUM-1:0][ADDR_W-1:0]    slv_awaddr,
   input  logic [NUM-1:0][7:0]           slv_awlen,
   input  logic [NUM-1:0][2:0]           slv_awsize,
   input  logic [NUM-1:0][1:0]           slv_awburst,
   input  logic [NUM-1:0]                slv_wvalid,
   output logic [NUM-1:0]                slv_wready,
   input  logic [NUM-1:0][DATA_W-1:0]    slv_wdata,
   input  logic [NUM-1:0][DATA_W/8-1:0]  slv_wstrb,
   input  logic [NUM-1:0]                slv_wlast,
   output logic [NUM-1:0]                slv_bvalid,
   input  logic [NUM-1:0]                slv_bready,
   output logic [NUM-1:0][ID_W-1:0]      slv_bid,
   output logic [NUM-1:0][1:0]           slv_bresp,
   // downstream write port
   output logic                          mst_awvalid,
   input  logic                          mst_awready,
   output logic [MID_W-1:0]              mst_awid,
   output logic [ADDR_W-1:0]             mst_awaddr,
   output logic [7:0]                    mst_awlen,
   output logic [2:0]                    mst_awsize,
   output logic [1:0]                    mst_awburst,
   output logic                          mst_wvalid,
   input  logic                          mst_wready,
   output logic [DATA_W-1:0]             mst_wdata,
   output logic [DATA_W/8-1:0]           mst_wstrb,
   output logic                          mst_wlast,
   input  logic                          mst_bvalid,
   output logic                          mst_bready,
   input  logic [MID_W-1:0]              mst_bid,
   input  logic [1:0]                    mst_bresp
);

   localparam int NSIZE = $clog2(NUM);
   localparam int PW    = (WDEPTH > 1) ? $clog2(WDEPTH) : 1;
   localparam int CW    = $clog2(WDEPTH + 1);

   if (ID_W + NSIZE != MID_W) begin : g_idsize_check
      $error("axi4_wr_mix_interconnect_m2s: ID_W + clog2(NUM) must equal MID_W");
   end

   logic [NSIZE-1:0] rr;
   logic [NSIZE-1:0] gnt_idx;
   logic             gnt_hit;
   logic             grant;
   logic             pop;
   logic [NSIZE-1:0] fifo_mem [WDEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic [NSIZE-1:0] head;
   logic [NSIZE-1:0] bport;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(WDEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Round-robin search from rr upward; the lowest offset that is requesting wins.
   always_comb begin
      logic [NSIZE-1:0] cand;
      cand    = '0;
      gnt_hit = 1'b0;
      gnt_idx = '0;
      for (int i = NUM - 1; i >= 0; i--) begin
         cand = NSIZE'((int'(rr) + i) % NUM);
         if (slv_awvalid[cand]) begin
            gnt_hit = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   // A pop in the same cycle does not free a slot for the grant: full always blocks.
   assign grant       = axi_aresetn && gnt_hit && (!mst_awvalid || mst_awready) &&
                        (cnt != CW'(WDEPTH));
   assign slv_awready = NUM'(grant) << gnt_idx;
   assign head        = fifo_mem[rd_ptr];
   assign pop         = mst_wvalid && mst_wready && mst_wlast;

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         mst_awvalid <= 1'b0;
         rr          <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         cnt         <= '0;
      end else begin
         if (grant) begin
            mst_awvalid <= 1'b1;
            rr          <= (gnt_idx == NSIZE'(NUM - 1)) ? '0 : gnt_idx + 1'b1;
            wr_ptr      <= ptr_inc(wr_ptr);
         end else if (mst_awready) begin
            mst_awvalid <= 1'b0;
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({grant, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Payload and routing entries carry no reset; their valid flags guard them.
   always_ff @(posedge axi_aclk) begin
      if (grant) begin
         mst_awid         <= {slv_awid[gnt_idx], gnt_idx};
         mst_awaddr       <= slv_awaddr[gnt_idx];
         mst_awlen        <= slv_awlen[gnt_idx];
         mst_awsize       <= slv_awsize[gnt_idx];
         mst_awburst      <= slv_awburst[gnt_idx];
         fifo_mem[wr_ptr] <= gnt_idx;
      end
   end

   always_comb begin
      mst_wvalid = 1'b0;
      mst_wdata  = '0;
      mst_wstrb  = '0;
      mst_wlast  = 1'b0;
      slv_wready = '0;
      if (cnt != '0) begin
         mst_wvalid       = slv_wvalid[head];
         mst_wdata        = slv_wdata[head];
         mst_wstrb        = slv_wstrb[head];
         mst_wlast        = slv_wlast[head];
         slv_wready[head] = mst_wready;
      end
   end

   // The low id bits name the originating port; the rest is the upstream id.
   assign bport = mst_bid[NSIZE-1:0];

   always_comb begin
      slv_bvalid        = '0;
      slv_bvalid[bport] = mst_bvalid;
      mst_bready        = slv_bready[bport];
      for (int k = 0; k < NUM; k++) begin
         slv_bid[k]   = mst_bid[MID_W-1:NSIZE];
         slv_bresp[k] = mst_bresp;
      end
   end

`ifdef AXI4_WR_MIX_INTERCONNECT_TRACK_EN
   (* dont_touch = "true" *) logic [MID_W-1:0] track_awid;
   (* dont_touch = "true" *) logic [MID_W-1:0] track_bid;
   (* dont_touch = "true" *) logic [NSIZE-1:0] track_wport;

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         track_awid  <= '0;
         track_bid   <= '0;
         track_wport <= '0;
      end else begin
         if (mst_awvalid && mst_awready) track_awid  <= mst_awid;
         if (mst_bvalid && mst_bready)   track_bid   <= mst_bid;
         if (pop)                        track_wport <= head;
      end
   end
`else
`endif

endmodule

// File: tb/tb_axi4_wr_mix_interconnect_m2s.sv
// Scoreboard bench for axi4_wr_mix_interconnect_m2s (NUM=4, WDEPTH=2, 2-bit upstream ids).
module tb_axi4_wr_mix_interconnect_m2s;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [3:0]            slv_awvalid, slv_awready;
   logic [3:0][1:0]       slv_awid;
   logic [3:0][31:0]      slv_awaddr;
   logic [3:0][7:0]       slv_awlen;
   logic [3:0][2:0]       slv_awsize;
   logic [3:0][1:0]       slv_awburst;
   logic [3:0]            slv_wvalid, slv_wready, slv_wlast;
   logic [3:0][31:0]      slv_wdata;
   logic [3:0][3:0]       slv_wstrb;
   logic [3:0]            slv_bvalid, slv_bready;
   logic [3:0][1:0]       slv_bid, slv_bresp;
   logic                  mst_awvalid, mst_awready;
   logic [3:0]            mst_awid;
   logic [31:0]           mst_awaddr;
   logic [7:0]            mst_awlen;
   logic [2:0]            mst_awsize;
   logic [1:0]            mst_awburst;
   logic                  mst_wvalid, mst_wready, mst_wlast;
   logic [31:0]           mst_wdata;
   logic [3:0]            mst_wstrb;
   logic                  mst_bvalid, mst_bready;
   logic [3:0]            mst_bid;
   logic [1:0]            mst_bresp;

   axi4_wr_mix_interconnect_m2s #(
      .NUM(4), .WDEPTH(2), .ID_W(2), .MID_W(4), .ADDR_W(32), .DATA_W(32)
   ) dut (
      .axi_aclk(clk), .axi_aresetn(rst_n),
      .slv_awvalid(slv_awvalid), .slv_awready(slv_awready), .slv_awid(slv_awid),
      .slv_awaddr(slv_awaddr), .slv_awlen(slv_awlen), .slv_awsize(slv_awsize),
      .slv_awburst(slv_awburst), .slv_wvalid(slv_wvalid), .slv_wready(slv_wready),
      .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb), .slv_wlast(slv_wlast),
      .slv_bvalid(slv_bvalid), .slv_bready(slv_bready), .slv_bid(slv_bid),
      .slv_bresp(slv_bresp),
      .mst_awvalid(mst_awvalid), .mst_awready(mst_awready), .mst_awid(mst_awid),
      .mst_awaddr(mst_awaddr), .mst_awlen(mst_awlen), .mst_awsize(mst_awsize),
      .mst_awburst(mst_awburst), .mst_wvalid(mst_wvalid), .mst_wready(mst_wready),
      .mst_wdata(mst_wdata), .mst_wstrb(mst_wstrb), .mst_wlast(mst_wlast),
      .mst_bvalid(mst_bvalid), .mst_bready(mst_bready), .mst_bid(mst_bid),
      .mst_bresp(mst_bresp)
   );

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [41:0] aw_q [4][$];   // {id, addr, len} per upstream port
   logic [32:0] w_q  [4][$];   // {last, data} per upstream port
   logic [63:0] exp_aw [$];
   logic [63:0] exp_w  [$];
   int          grant_log [$];
   logic [3:0]  aw_acc, w_acc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic push_aw(input int k, input logic [1:0] id, input logic [31:0] addr,
                          input logic [7:0] len);
      logic [1:0] kk;
      kk = k[1:0];
      aw_q[k].push_back({id, addr, len});
      exp_aw.push_back(64'({id, kk, addr, len, 3'd2, 2'b01}));
   endtask

   task automatic push_w(input int k, input int n, input logic [31:0] base);
      for (int b = 0; b < n; b++) begin
         w_q[k].push_back({(b == n - 1), base + 32'(b)});
         exp_w.push_back(64'({(b == n - 1), base + 32'(b)}));
      end
   endtask

   function automatic int glog(input int i);
      return (i < grant_log.size()) ? grant_log[i] : -1;
   endfunction

   task automatic clear_all();
      for (int k = 0; k < 4; k++) begin
         aw_q[k].delete();
         w_q[k].delete();
      end
      exp_aw.delete();
      exp_w.delete();
      grant_log.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_all();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n;
      n = 0;
      while ((exp_aw.size() != 0 || exp_w.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(exp_aw.size() + exp_w.size()), 64'd0);
      @(negedge clk);
   endtask

   // Upstream port models: present queue heads, retire entries on accepted handshakes.
   always @(negedge clk) begin
      aw_acc = slv_awvalid & slv_awready;
      w_acc  = slv_wvalid & slv_wready;
   end

   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 4; k++) begin
         if (aw_acc[k] && aw_q[k].size() > 0) begin
            void'(aw_q[k].pop_front());
            grant_log.push_back(k);
         end
         if (w_acc[k] && w_q[k].size() > 0) void'(w_q[k].pop_front());
         if (aw_q[k].size() > 0) begin
            {slv_awid[k], slv_awaddr[k], slv_awlen[k]} = aw_q[k][0];
            slv_awvalid[k] = 1'b1;
         end else begin
            slv_awvalid[k] = 1'b0;
         end
         if (w_q[k].size() > 0) begin
            {slv_wlast[k], slv_wdata[k]} = w_q[k][0];
            slv_wvalid[k] = 1'b1;
         end else begin
            slv_wvalid[k] = 1'b0;
         end
      end
   end

   // Downstream monitor: every handshake must match the next expected item.
   always @(negedge clk) begin
      logic [63:0] e;
      if (rst_n) begin
         if (mst_awvalid && mst_awready) begin
            if (exp_aw.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
            else begin
               e = exp_aw.pop_front();
               check("aw_beat", 64'({mst_awid, mst_awaddr, mst_awlen, mst_awsize, mst_awburst}), e);
            end
         end
         if (mst_wvalid && mst_wready) begin
            if (exp_w.size() == 0) check("w_unexpected", 64'd1, 64'd0);
            else begin
               e = exp_w.pop_front();
               check("w_beat", 64'({mst_wlast, mst_wdata}), e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n       = 1'b0;
      slv_awvalid = '0; slv_awid = '0; slv_awaddr = '0; slv_awlen = '0;
      slv_wvalid  = '0; slv_wdata = '0; slv_wlast = '0; slv_bready = '0;
      for (int k = 0; k < 4; k++) begin
         slv_awsize[k]  = 3'd2;
         slv_awburst[k] = 2'b01;
         slv_wstrb[k]   = 4'hf;
      end
      mst_awready = 1'b1; mst_wready = 1'b1;
      mst_bvalid  = 1'b0; mst_bid = '0; mst_bresp = '0;

      // Reset state with a request pending
      aw_q[0].push_back({2'd1, 32'h40, 8'd0});
      repeat (2) @(negedge clk);
      check("rst_awvalid", 64'(mst_awvalid), 64'd0);
      check("rst_wvalid", 64'(mst_wvalid), 64'd0);
      check("rst_wready", 64'(slv_wready), 64'd0);
      check("rst_awready", 64'(slv_awready), 64'd0);
      aw_q[0].delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single burst from port 2
      push_aw(2, 2'd1, 32'h100, 8'd3);
      push_w(2, 4, 32'h2000);
      n = 0;
      while (!mst_awvalid && n < 10) begin @(negedge clk); n++; end
      check("t1_awvalid", 64'(mst_awvalid), 64'd1);
      check("t1_awid", 64'(mst_awid), 64'b0110);
      check("t1_awaddr", 64'(mst_awaddr), 64'h100);
      wait_drain(40, "t1_drain");
      w_q[2].push_back({1'b1, 32'hDEAD});
      @(negedge clk);
      check("t1_empty_wvalid", 64'(mst_wvalid), 64'd0);
      check("t1_empty_wready", 64'(slv_wready), 64'd0);
      w_q[2].delete();
      @(negedge clk);

      // Simultaneous requests 0, 1, 3 after reset
      do_reset();
      @(negedge clk);
      push_aw(0, 2'd1, 32'h000, 8'd0);
      push_aw(1, 2'd2, 32'h040, 8'd1);
      push_aw(3, 2'd3, 32'h0c0, 8'd2);
      push_w(0, 1, 32'hA000);
      push_w(1, 2, 32'hB000);
      push_w(3, 3, 32'hD000);
      wait_drain(60, "t2_drain");
      check("t2_grant_n", 64'(grant_log.size()), 64'd3);
      check("t2_grant0", 64'(glog(0)), 64'd0);
      check("t2_grant1", 64'(glog(1)), 64'd1);
      check("t2_grant2", 64'(glog(2)), 64'd3);
      grant_log.delete();
      push_aw(0, 2'd0, 32'h010, 8'd0);
      push_aw(2, 2'd0, 32'h200, 8'd0);
      push_w(0, 1, 32'hA100);
      push_w(2, 1, 32'hC100);
      wait_drain(40, "t2_rr_drain");
      check("t2_rr_first", 64'(glog(0)), 64'd0);
      check("t2_rr_second", 64'(glog(1)), 64'd2);

      // Response routing
      mst_bvalid = 1'b1; mst_bid = 4'b1011; mst_bresp = 2'b10; slv_bready = 4'b1000;
      #1;
      check("b_bvalid", 64'(slv_bvalid), 64'b1000);
      check("b_bid3", 64'(slv_bid[3]), 64'b10);
      check("b_bresp3", 64'(slv_bresp[3]), 64'b10);
      check("b_bready_hi", 64'(mst_bready), 64'd1);
      slv_bready = 4'b0111;
      #1;
      check("b_bready_lo", 64'(mst_bready), 64'd0);
      mst_bid = 4'b0001; slv_bready = 4'b0010;
      #1;
      check("b_bvalid_p1", 64'(slv_bvalid), 64'b0010);
      check("b_bid1", 64'(slv_bid[1]), 64'b00);
      check("b_bready_p1", 64'(mst_bready), 64'd1);
      mst_bvalid = 1'b0;
      #1;
      check("b_idle", 64'(slv_bvalid), 64'd0);
      slv_bready = '0;
      @(negedge clk);

      // Full routing FIFO blocks the third grant until the first wlast
      grant_log.delete();
      push_aw(0, 2'd1, 32'h400, 8'd0);
      push_aw(1, 2'd1, 32'h440, 8'd0);
      push_aw(2, 2'd1, 32'h480, 8'd0);
      n = 0;
      while (grant_log.size() < 2 && n < 10) begin @(negedge clk); n++; end
      check("t4_two_grants", 64'(grant_log.size()), 64'd2);
      repeat (3) begin
         @(negedge clk);
         check("t4_blocked", 64'(slv_awready), 64'd0);
      end
      push_w(0, 1, 32'hE000);
      @(negedge clk);
      check("t4_wlast_beat", 64'({mst_wvalid, mst_wlast}), 64'b11);
      check("t4_full_pop_block", 64'(slv_awready), 64'd0);
      @(negedge clk);
      check("t4_grant_after", 64'(slv_awready), 64'b0100);
      push_w(1, 1, 32'hE100);
      push_w(2, 1, 32'hE200);
      wait_drain(40, "t4_drain");
      check("t4_grant_order", 64'({glog(0) == 0, glog(1) == 1, glog(2) == 2}), 64'b111);

      // Downstream AW stall
      @(posedge clk); #1 mst_awready = 1'b0;
      @(negedge clk);
      push_aw(1, 2'd2, 32'h280, 8'd1);
      push_w(1, 2, 32'hF100);
      n = 0;
      while (!mst_awvalid && n < 10) begin @(negedge clk); n++; end
      push_aw(2, 2'd1, 32'h2c0, 8'd0);
      push_w(2, 1, 32'hF200);
      repeat (5) begin
         @(negedge clk);
         check("t5_hold", 64'({mst_awvalid, mst_awid, mst_awaddr}), 64'({1'b1, 4'b1001, 32'h280}));
         check("t5_no_grant", 64'(slv_awready), 64'd0);
      end
      @(posedge clk); #1 mst_awready = 1'b1;
      @(negedge clk);
      check("t5_drain_grant", 64'(slv_awready), 64'b0100);
      wait_drain(40, "t5_drain");

      // Reset in the middle of a long burst
      @(posedge clk); #1 mst_awready = 1'b0;
      @(negedge clk);
      push_aw(3, 2'd3, 32'h300, 8'd7);
      push_w(3, 8, 32'h3000);
      n = 0;
      while (!(mst_wvalid && mst_wdata == 32'h3001) && n < 20) begin @(negedge clk); n++; end
      check("t6_beat2", 64'({mst_wvalid, mst_wdata}), 64'({1'b1, 32'h3001}));
      check("t6_awvalid_pre", 64'(mst_awvalid), 64'd1);
      #1;
      rst_n = 1'b0;
      clear_all();
      #1;
      check("t6_rst_wvalid", 64'(mst_wvalid), 64'd0);
      check("t6_rst_awvalid", 64'(mst_awvalid), 64'd0);
      check("t6_rst_wready", 64'(slv_wready), 64'd0);
      check("t6_rst_awready", 64'(slv_awready), 64'd0);
      mst_awready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      w_q[3].push_back({1'b0, 32'h3001});
      @(negedge clk);
      check("t6_no_resume_wvalid", 64'(mst_wvalid), 64'd0);
      check("t6_no_resume_wready", 64'(slv_wready), 64'd0);
      w_q[3].delete();
      @(negedge clk);
      grant_log.delete();
      push_aw(1, 2'd0, 32'h1000, 8'd1);
      push_w(1, 2, 32'h1100);
      wait_drain(40, "t6_drain");
      check("t6_new_grant", 64'(glog(0)), 64'd1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/axi4_wr_mix_interconnect_m2s.md
AXI4_WR_MIX_INTERCONNECT_M2S -- requirements
Module: axi4_wr_mix_interconnect_M2S

Interface
REQ-001 Parameter NUM, default 8: number of upstream write slaver ports; NSIZE = $clog2(NUM).
REQ-002 Parameter WDEPTH, default 4: number of W-route FIFO entries, i.e. AW bursts accepted but W not yet finished.
REQ-003 master.axi_aclk  input  1  sole clock; all logic is clocked on its rising edge.
REQ-004 master.axi_aresetn  input  1  reset, asynchronous, active-low.
REQ-005 slaver  axi_inf.slaver_wr [NUM-1:0]  AW/W/B channels  upstream write ports.
REQ-006 master  axi_inf.master_wr  AW/W/B channels  single downstream write port.
REQ-007 The elaboration check SHALL require slaver[0].IDSIZE+NSIZE == master.IDSIZE; on mismatch it SHALL issue $error and $stop.

Function
REQ-008 AW arbitration SHALL be round-robin over slaver[k].axi_awvalid, searching from pointer rr upward with wrap; after a grant to port k, rr SHALL become (k+1) mod NUM.
REQ-009 AW output register, captured on grant: master.axi_awid = {slaver[k].axi_awid, k[NSIZE-1:0]}, plus awaddr, awlen, awsize, awburst.
REQ-010 slaver[k].axi_awready SHALL be 1 only in the grant cycle, and only for k.
REQ-011 A grant SHALL occur only when the AW register is empty or being drained (master awvalid&&awready), and the W-route FIFO is not full.
REQ-012 master.axi_awvalid SHALL rise the cycle after the grant and hold with a stable payload until master.axi_awready.
REQ-013 On grant, port index k SHALL be pushed into the W-route FIFO in the same cycle.
REQ-014 A full FIFO SHALL block the grant even if a pop occurs in the same cycle.
REQ-015 W routing, combinational, from FIFO head h:
- master.axi_wvalid/wdata/wstrb/wlast = slaver[h] W signals;
- slaver[h].axi_wready = master.axi_wready;
- every other slaver wready = 0.
REQ-016 FIFO empty: master.axi_wvalid = 0 and all slaver wready = 0.
REQ-017 The FIFO SHALL pop on master wvalid&&wready&&wlast.
- Push and pop in the same cycle leave the count unchanged.
- W beats MAY reach master before their AW.
REQ-018 B routing, combinational, with p = master.axi_bid[NSIZE-1:0]:
- slaver[p].axi_bvalid = master.axi_bvalid;
- slaver[p].axi_bresp = master.axi_bresp;
- slaver[p].axi_bid = master.axi_bid[master.IDSIZE-1:NSIZE];
- master.axi_bready = slaver[p].axi_bready;
- every other slaver bvalid = 0.
REQ-019 The block SHALL impose no limit on B ordering and SHALL NOT block AW or W on outstanding B.

Reset
REQ-020 While master.axi_aresetn=0, regardless of what is in progress:
- AW register empty, master.axi_awvalid = 0;
- FIFO empty, so master.axi_wvalid = 0 and all slaver wready = 0;
- rr = 0;
- all slaver awready = 0.
REQ-021 Reset asserted mid-burst SHALL discard all in-flight routing state; no partial burst resumes after release.

Configuration
REQ-022 Macro AXI4_WR_MIX_INTERCONNECT_TRACK_EN, when defined, SHALL add dont_touch debug registers, each reset to 0:
- track_awid: last master AW handshake id;
- track_bid: last master B handshake id;
- track_wport: last popped FIFO index.
REQ-023 When AXI4_WR_MIX_INTERCONNECT_TRACK_EN is undefined, these registers SHALL be absent, with identical port behaviour and identical cycle timing.

Verification
All scenarios use NUM=4, slaver IDSIZE=2, master IDSIZE=4 unless stated.
REQ-024 slaver[2] AW id=1, addr=0x100, len=3 -> master awid=4'b0110, awaddr=0x100; then 4 W beats from slaver[2] reach master, wlast on beat 4, FIFO empty afterwards.
REQ-025 slavers 0, 1, 3 awvalid in the same cycle after reset -> grants 0, 1, 3 on consecutive accepts, rr=0 after; W bursts forwarded in order 0, 1, 3.
REQ-026 master bvalid with bid=4'b1011, bresp=2'b10 -> slaver[3] bvalid=1, bid=2'b10, bresp=2'b10; slavers 0-2 bvalid=0; master bready follows slaver[3].bready.
REQ-027 WDEPTH=2: three AWs issued with no W -> third slaver awready stays 0 until the first burst's wlast handshake, then granted the following cycle.
REQ-028 master awready held 0 for 5 cycles -> awvalid stays 1 with unchanged awid/awaddr; no further slaver awready until drained.
REQ-029 reset pulsed during beat 2 of a len=7 burst -> same cycle master wvalid=0, awvalid=0; after release FIFO empty, new AW from slaver[1] served normally.
